// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  localparam int M0           = 0;
  localparam int M1           = 1;
  localparam int MAX_LOCK_DEF = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the master that wins a tie
// and flips to the loser on every grant, or is loaded directly by the owner FSM.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       load_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (en_i) begin
      if (&req_i) gnt_o[ptr_q] = 1'b1;
      else        gnt_o        = req_i;
    end
    if (load_i)                ptr_d = ptr_i;
    else if (en_i && |gnt_o)   ptr_d = gnt_o[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between two masters: round-robin in IDLE, bounded lock
// ownership in OWN0/OWN1, combinational address mux and registered read return.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEF,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_mask,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_mask,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic [AW-1:0] ram_a,
  output logic [31:0]   ram_di,
  output logic [3:0]    ram_m,
  output logic          ram_we,
  input  logic [31:0]   ram_do
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    req, lock, we, gnt, arb_gnt, rvalid_q;
  logic [31:0]   rdata0_q, rdata1_q;
  logic          ptr_load, ptr_val, own;

  assign req  = {m1_req,  m0_req};
  assign lock = {m1_lock, m0_lock};
  assign we   = {m1_we,   m0_we};

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .en_i   (state_q == IDLE),
    .load_i (ptr_load),
    .ptr_i  (ptr_val),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    gnt      = '0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_load = 1'b0;
    ptr_val  = 1'b0;
    own      = (state_q == OWN1);
    cnt_inc  = (cnt_q >= CW'(MAX_LOCK)) ? cnt_q : cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        gnt = arb_gnt;
        own = arb_gnt[M1];
        if (|arb_gnt && lock[own]) begin
          state_d = own ? OWN1 : OWN0;
          cnt_d   = CW'(1);
        end
      end
      OWN0, OWN1: begin
        if (!req[own]) begin
          state_d = IDLE;
        end else begin
          gnt[own] = 1'b1;
          cnt_d    = cnt_inc;
          if (!lock[own]) begin
            state_d = IDLE;
          end else if (cnt_inc == CW'(MAX_LOCK) && req[~own]) begin
            // Lock budget spent with the other master waiting: hand it the tie.
            state_d  = IDLE;
            ptr_load = 1'b1;
            ptr_val  = ~own;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) gnt = '0;
  end

  always_comb begin
    ram_a  = '0;
    ram_di = '0;
    ram_m  = '0;
    ram_we = 1'b0;
    if (gnt[M0]) begin
      ram_a  = m0_addr;
      ram_di = m0_wdata;
      ram_m  = m0_mask;
      ram_we = m0_we;
    end else if (gnt[M1]) begin
      ram_a  = m1_addr;
      ram_di = m1_wdata;
      ram_m  = m1_mask;
      ram_we = m1_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read data is captured at the grant edge and shown for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= gnt & ~we;
      if (gnt[M0] && !m0_we) rdata0_q <= ram_do;
      if (gnt[M1] && !m1_we) rdata1_q <= ram_do;
    end
  end

  assign m0_gnt    = gnt[M0];
  assign m1_gnt    = gnt[M1];
  assign m0_rvalid = rvalid_q[M0];
  assign m1_rvalid = rvalid_q[M1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at the default lock limit and one
// at MAX_LOCK=4, sharing stimulus, each with its own byte-maskable RAM model.
module tb_ram_arbiter;

  localparam int AW   = 32;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_mask, m1_mask;

  logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_ram_we;
  logic [31:0]   a_m0_rdata, a_m1_rdata, a_ram_di, a_ram_do;
  logic [AW-1:0] a_ram_a;
  logic [3:0]    a_ram_m;
  logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_ram_we;
  logic [31:0]   b_m0_rdata, b_m1_rdata, b_ram_di, b_ram_do;
  logic [AW-1:0] b_ram_a;
  logic [3:0]    b_ram_m;

  ram_arbiter #(.AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_mask(m0_mask), .m0_gnt(a_m0_gnt),
    .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_mask(m1_mask), .m1_gnt(a_m1_gnt),
    .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .ram_a(a_ram_a), .ram_di(a_ram_di), .ram_m(a_ram_m), .ram_we(a_ram_we),
    .ram_do(a_ram_do)
  );

  ram_arbiter #(.MAX_LOCK(MAXB), .AW(AW)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_mask(m0_mask), .m0_gnt(b_m0_gnt),
    .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_mask(m1_mask), .m1_gnt(b_m1_gnt),
    .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .ram_a(b_ram_a), .ram_di(b_ram_di), .ram_m(b_ram_m), .ram_we(b_ram_we),
    .ram_do(b_ram_do)
  );

  logic [31:0] mem_a [256] = '{default: '0};
  logic [31:0] mem_b [256] = '{default: '0};

  assign a_ram_do = mem_a[a_ram_a[9:2]];
  assign b_ram_do = mem_b[b_ram_a[9:2]];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_ram_we && a_ram_m[i]) mem_a[a_ram_a[9:2]][8*i +: 8] <= a_ram_di[8*i +: 8];
      if (b_ram_we && b_ram_m[i]) mem_b[b_ram_a[9:2]][8*i +: 8] <= b_ram_di[8*i +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_mask = 4'hF;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_mask = 4'hF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic        eg0, eg1, ewe;
    logic [31:0] ea, ed;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0_prev, g1_prev;
    int   w0, w1;

    // r0 r1 w0 w1 | g0 g1 we | ram_a ram_di  (pointer starts at master 0)
    tbl[0]  = '{1, 1, 0, 0, 1, 0, 0, 32'h100, 32'h0A0A0A0A};
    tbl[1]  = '{1, 1, 0, 0, 0, 1, 0, 32'h200, 32'h0B0B0B0B};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 32'h100, 32'h0A0A0A0A};
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 0, 32'h100, 32'h0A0A0A0A};
    tbl[4]  = '{0, 1, 0, 0, 0, 1, 0, 32'h200, 32'h0B0B0B0B};
    tbl[5]  = '{0, 0, 1, 1, 0, 0, 0, 32'h000, 32'h00000000};
    tbl[6]  = '{1, 1, 0, 0, 1, 0, 0, 32'h100, 32'h0A0A0A0A};
    tbl[7]  = '{1, 1, 1, 1, 0, 1, 1, 32'h200, 32'h0B0B0B0B};
    tbl[8]  = '{1, 0, 1, 0, 1, 0, 1, 32'h100, 32'h0A0A0A0A};
    tbl[9]  = '{1, 1, 1, 0, 0, 1, 0, 32'h200, 32'h0B0B0B0B};
    tbl[10] = '{1, 1, 1, 0, 1, 0, 1, 32'h100, 32'h0A0A0A0A};

    // Reset state, with a write request pending to show the combinational gating.
    idle_inputs();
    m0_req = 1; m0_we = 1; m1_req = 1;
    #3;
    check("rst_m0_gnt", a_m0_gnt, 0);
    check("rst_m1_gnt", a_m1_gnt, 0);
    check("rst_ram_we", a_ram_we, 0);
    check("rst_ram_a", a_ram_a, 0);
    check("rst_rvalid", {a_m0_rvalid, a_m1_rvalid}, 0);
    check("rst_m0_rdata", a_m0_rdata, 0);
    check("rst_m1_rdata", a_m1_rdata, 0);

    // Unlocked arbitration table.
    do_reset();
    m0_addr = 32'h100; m1_addr = 32'h200;
    m0_wdata = 32'h0A0A0A0A; m1_wdata = 32'h0B0B0B0B;
    for (int i = 0; i < 11; i++) begin
      m0_req = tbl[i].r0; m1_req = tbl[i].r1;
      m0_we  = tbl[i].w0; m1_we  = tbl[i].w1;
      sample();
      check($sformatf("vec%0d_g0", i), a_m0_gnt, tbl[i].eg0);
      check($sformatf("vec%0d_g1", i), a_m1_gnt, tbl[i].eg1);
      check($sformatf("vec%0d_we", i), a_ram_we, tbl[i].ewe);
      check($sformatf("vec%0d_a", i), a_ram_a, tbl[i].ea);
      check($sformatf("vec%0d_di", i), a_ram_di, tbl[i].ed);
      step();
    end
    idle_inputs();

    // Preload words 0x00 and 0x04 through master 0.
    m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'h11111111;
    sample();
    check("pre0_we", a_ram_we, 1);
    step();
    m0_addr = 32'h4; m0_wdata = 32'h22222222;
    sample();
    check("pre1_we", a_ram_we, 1);
    step();

    // Both request unlocked reads after reset.
    do_reset();
    m0_req = 1; m0_addr = 32'h0;
    m1_req = 1; m1_addr = 32'h4;
    sample();
    check("rd_c1_g0", a_m0_gnt, 1);
    check("rd_c1_g1", a_m1_gnt, 0);
    step();
    m0_req = 0;
    sample();
    check("rd_c2_g1", a_m1_gnt, 1);
    check("rd_c2_g0", a_m0_gnt, 0);
    check("rd_c2_m0_rvalid", a_m0_rvalid, 1);
    check("rd_c2_m0_rdata", a_m0_rdata, 32'h11111111);
    check("rd_c2_m1_rvalid", a_m1_rvalid, 0);
    step();
    m1_req = 0;
    sample();
    check("rd_c3_m1_rvalid", a_m1_rvalid, 1);
    check("rd_c3_m1_rdata", a_m1_rdata, 32'h22222222);
    check("rd_c3_m0_rvalid", a_m0_rvalid, 0);
    step();
    sample();
    check("rd_c4_m1_rvalid", a_m1_rvalid, 0);
    check("rd_c4_m1_hold", a_m1_rdata, 32'h22222222);
    check("rd_c4_m0_hold", a_m0_rdata, 32'h11111111);
    step();

    // Masked write by m0, then m1 reads the same word next cycle.
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_mask = 4'b0011;
    sample();
    check("wr_g0", a_m0_gnt, 1);
    check("wr_ram_we", a_ram_we, 1);
    check("wr_ram_m", a_ram_m, 4'b0011);
    check("wr_ram_di", a_ram_di, 32'hDEADBEEF);
    check("wr_ram_a", a_ram_a, 32'h10);
    step();
    idle_inputs();
    m1_req = 1; m1_addr = 32'h10;
    sample();
    check("wr_rd_g1", a_m1_gnt, 1);
    check("wr_no_rvalid", a_m0_rvalid, 0);
    step();
    m1_req = 0;
    sample();
    check("wr_rd_rvalid", a_m1_rvalid, 1);
    check("wr_rd_rdata", a_m1_rdata, 32'h0000BEEF);
    step();

    // m1 holds a lock for five grants while m0 waits.
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h4;
    sample();
    check("lk_c1_g1", a_m1_gnt, 1);
    step();
    m0_req = 1; m0_addr = 32'h0;
    for (int k = 2; k <= 5; k++) begin
      sample();
      check($sformatf("lk_c%0d_g1", k), a_m1_gnt, 1);
      check($sformatf("lk_c%0d_g0", k), a_m0_gnt, 0);
      step();
    end
    m1_lock = 0;
    sample();
    check("lk_c6_g1", a_m1_gnt, 1);
    check("lk_c6_g0", a_m0_gnt, 0);
    step();
    m1_req = 0;
    sample();
    check("lk_c7_g0", a_m0_gnt, 1);
    step();
    idle_inputs();

    // Owner drops its request: one empty cycle, then normal arbitration.
    do_reset();
    m0_req = 1; m0_lock = 1;
    sample();
    check("drop_g0", a_m0_gnt, 1);
    step();
    m0_req = 0; m1_req = 1;
    sample();
    check("drop_empty_g1", a_m1_gnt, 0);
    check("drop_empty_g0", a_m0_gnt, 0);
    step();
    sample();
    check("drop_next_g1", a_m1_gnt, 1);
    step();
    idle_inputs();

    // Forced release at MAX_LOCK=4, then saturation with m1 idle.
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h0;
    m1_req = 1; m1_addr = 32'h4;
    for (int k = 1; k <= MAXB; k++) begin
      sample();
      check($sformatf("frc_c%0d_g0", k), b_m0_gnt, 1);
      check($sformatf("frc_c%0d_g1", k), b_m1_gnt, 0);
      step();
    end
    sample();
    check("frc_rel_g1", b_m1_gnt, 1);
    check("frc_rel_g0", b_m0_gnt, 0);
    step();
    m1_req = 0;
    sample();
    check("sat_g0_first", b_m0_gnt, 1);
    step();
    for (int k = 0; k < 8; k++) begin
      sample();
      check($sformatf("sat_g0_%0d", k), b_m0_gnt, 1);
      step();
    end
    m1_req = 1;
    sample();
    check("sat_last_g0", b_m0_gnt, 1);
    check("sat_last_g1", b_m1_gnt, 0);
    step();
    sample();
    check("sat_rel_g1", b_m1_gnt, 1);
    step();
    idle_inputs();

    // Reset mid-lock with a read outstanding.
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h0;
    sample();
    check("mr_g0", a_m0_gnt, 1);
    step();
    check("mr_rvalid_pre", a_m0_rvalid, 1);
    #1;
    rst_n = 1'b0;
    m0_we = 1;
    #1;
    check("mr_rvalid", a_m0_rvalid, 0);
    check("mr_gnt", a_m0_gnt, 0);
    check("mr_ram_we", a_ram_we, 0);
    check("mr_rdata", a_m0_rdata, 0);
    m0_req = 0; m0_we = 0; m0_lock = 0;
    m1_req = 1; m1_addr = 32'h4;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample();
    check("mr_idle_g1", a_m1_gnt, 1);
    step();
    do_reset();
    m0_req = 1; m1_req = 1;
    sample();
    check("mr_prio_g0", a_m0_gnt, 1);
    check("mr_prio_g1", a_m1_gnt, 0);
    step();

    // Random traffic on the MAX_LOCK=4 instance; masters hold requests until granted.
    do_reset();
    g0_prev = 1; g1_prev = 1; w0 = 0; w1 = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!m0_req || g0_prev) begin
        m0_req = ($urandom_range(0, 2) != 0); m0_lock = ($urandom_range(0, 3) != 0);
        m0_we = 1'($urandom_range(0, 1)); m0_addr = 32'h300 + 32'($urandom_range(0, 63)) * 4;
        m0_wdata = $urandom; m0_mask = 4'($urandom_range(0, 15));
      end
      if (!m1_req || g1_prev) begin
        m1_req = ($urandom_range(0, 2) != 0); m1_lock = ($urandom_range(0, 3) != 0);
        m1_we = 1'($urandom_range(0, 1)); m1_addr = 32'h300 + 32'($urandom_range(0, 63)) * 4;
        m1_wdata = $urandom; m1_mask = 4'($urandom_range(0, 15));
      end
      sample();
      check("rnd_mutex", b_m0_gnt & b_m1_gnt, 0);
      check("rnd_we_gnt", b_ram_we & ~(b_m0_gnt | b_m1_gnt), 0);
      check("rnd_gnt_req", (b_m0_gnt & ~m0_req) | (b_m1_gnt & ~m1_req), 0);
      w0 = (m0_req && !b_m0_gnt) ? w0 + 1 : 0;
      w1 = (m1_req && !b_m1_gnt) ? w1 + 1 : 0;
      check("rnd_wait0", w0 > MAXB + 1, 0);
      check("rnd_wait1", w1 > MAXB + 1, 0);
      g0_prev = b_m0_gnt;
      g1_prev = b_m1_gnt;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
